// File: rtl/hc85_cascade_seq.sv
// ---------------------------------------------------------------------------
// hc85_cascade_seq
//
// Purpose
//   Compares two NIBBLES*4-bit operands using a single external 4-bit HC85
//   magnitude comparator. The comparator is used one nibble per cycle,
//   least-significant nibble first. Each nibble's result is registered and
//   fed back as the cascade input for the next nibble, so the final HC85
//   output is the comparison of the full operands.
//
// Handshake
//   A request is made by holding start high at a rising edge. It is accepted
//   only when the block is not busy (IDLE or DONE). On acceptance op_a, op_b
//   and cas_in are captured. Completion is signalled by a single-cycle done
//   pulse. result is valid while done is high and holds its value until the
//   next done pulse or reset. A start seen while busy is dropped and has no
//   effect.
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   start    : request (accepted in IDLE or DONE)
//   op_a     : operand A, W = 4*NIBBLES bits
//   op_b     : operand B, W bits
//   cas_in   : external cascade {gt,eq,lt}
//   busy     : high while nibbles are being compared
//   done     : one-cycle completion pulse
//   result   : {A>B, A==B, A<B} of the full operands
//   cmp_a    : nibble of A driven to the HC85
//   cmp_b    : nibble of B driven to the HC85
//   cmp_cas  : cascade input driven to the HC85
//   cmp_q    : HC85 output (combinational in cmp_a/cmp_b/cmp_cas)
// ---------------------------------------------------------------------------
module hc85_cascade_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   op_a,
    input  logic [4*NIBBLES-1:0]   op_b,
    input  logic [2:0]             cas_in,
    output logic                   busy,
    output logic                   done,
    output logic [2:0]             result,
    output logic [3:0]             cmp_a,
    output logic [3:0]             cmp_b,
    output logic [2:0]             cmp_cas,
    input  logic [2:0]             cmp_q
);

    localparam int W     = 4 * NIBBLES;
    // At least one bit, so that NIBBLES=1 still gets a legal index register.
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [2:0]       cas_reg;
    logic             accept;

    // A new request can be taken whenever the comparator is not in use.
    // DONE is included so back-to-back requests need no IDLE cycle.
    assign accept = start && (state != S_RUN);

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            cas_reg <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= 3'b000;
        end else begin
            // done is a pulse; it is only raised on the transition into DONE.
            done <= 1'b0;

            if (accept) begin
                a_reg   <= op_a;
                b_reg   <= op_b;
                cas_reg <= cas_in;
                idx     <= '0;
                busy    <= 1'b1;
                state   <= S_RUN;
            end else begin
                case (state)
                    S_RUN: begin
                        // The nibble result becomes the cascade for the next,
                        // more significant nibble.
                        cas_reg <= cmp_q;
                        if (idx == LAST_IDX) begin
                            // Final nibble: cmp_q is already the full-width
                            // answer, so publish it together with done.
                            // idx is held so it never passes NIBBLES-1.
                            result <= cmp_q;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            state  <= S_DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    S_DONE: begin
                        // No start this cycle (accept would have fired).
                        state <= S_IDLE;
                    end
                    S_IDLE: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Comparator drive
    //   Decoded only from registered state, so the HC85 sees stable inputs
    //   for the whole cycle. Outside RUN everything is held at zero and
    //   cmp_q is not used.
    // ------------------------------------------------------------------
    always_comb begin
        cmp_a   = 4'h0;
        cmp_b   = 4'h0;
        cmp_cas = 3'b000;
        if (state == S_RUN) begin
            cmp_cas = cas_reg;
            // Constant-index selection avoids a variable part-select whose
            // index width would depend on NIBBLES.
            for (int k = 0; k < NIBBLES; k++) begin
                if (idx == IDX_W'(k)) begin
                    cmp_a = a_reg[4*k +: 4];
                    cmp_b = b_reg[4*k +: 4];
                end
            end
        end
    end

endmodule

// File: tb/tb_hc85_cascade_seq.sv
module tb_hc85_cascade_seq;

  localparam int N = 4;
  localparam int W = 4 * N;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [2:0]   cas_in;
  logic         busy;
  logic         done;
  logic [2:0]   result;
  logic [3:0]   cmp_a;
  logic [3:0]   cmp_b;
  logic [2:0]   cmp_cas;
  logic [2:0]   cmp_q;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  hc85_cascade_seq #(.NIBBLES(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .cas_in  (cas_in),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .cmp_a   (cmp_a),
    .cmp_b   (cmp_b),
    .cmp_cas (cmp_cas),
    .cmp_q   (cmp_q)
  );

  // Behavioural HC85: magnitude first, cascade only on equal nibbles.
  function automatic logic [2:0] cas_rule(input logic [2:0] c);
    return c[1] ? 3'b010 : {c[2], 1'b0, c[0]};
  endfunction

  always_comb begin
    if (cmp_a > cmp_b)      cmp_q = 3'b100;
    else if (cmp_a < cmp_b) cmp_q = 3'b001;
    else                    cmp_q = cas_rule(cmp_cas);
  end

  // Comparison of the low nib nibbles of a and b with cascade c; with
  // nib==0 nothing has been compared yet and the cascade is untouched.
  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] c, input int nib);
    logic [W-1:0] mask;
    logic [W-1:0] la;
    logic [W-1:0] lb;
    if (nib == 0) return c;
    mask = (nib >= N) ? {W{1'b1}} : ((W'(1) << (4 * nib)) - W'(1));
    la = a & mask;
    lb = b & mask;
    if (la > lb) return 3'b100;
    if (la < lb) return 3'b001;
    return cas_rule(c);
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  logic [2:0]   exp_q[$];
  int           m_run = -1;   // -1: not running, else nibble index in use
  bit           m_done = 1'b0;
  bit           m_live = 1'b0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic [2:0]   m_cas = '0;
  logic [2:0]   m_res = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run  = -1;
      m_done = 1'b0;
      m_res  = 3'b000;
      exp_q.delete();
      m_live = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_run == N - 1) begin
        m_run  = -1;
        m_done = 1'b1;
        if (exp_q.size() > 0) m_res = exp_q.pop_front();
        else begin
          failures++;
          $display("FAIL sb_empty: done expected with no queued operation");
        end
      end else if (m_run >= 0) begin
        m_run++;
      end else if (start) begin
        m_a   = op_a;
        m_b   = op_b;
        m_cas = cas_in;
        exp_q.push_back(ref_cmp(op_a, op_b, cas_in, N));
        m_run = 0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [3:0] ea;
    logic [3:0] eb;
    logic [2:0] ec;
    if (m_live) begin
      ea = 4'h0;
      eb = 4'h0;
      ec = 3'b000;
      if (m_run >= 0) begin
        ea = m_a[4*m_run +: 4];
        eb = m_b[4*m_run +: 4];
        ec = ref_cmp(m_a, m_b, m_cas, m_run);
      end
      chk("cyc_busy",    W'(busy),    W'(m_run >= 0));
      chk("cyc_done",    W'(done),    W'(m_done));
      chk("cyc_result",  W'(result),  W'(m_res));
      chk("cyc_cmp_a",   W'(cmp_a),   W'(ea));
      chk("cyc_cmp_b",   W'(cmp_b),   W'(eb));
      chk("cyc_cmp_cas", W'(cmp_cas), W'(ec));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 20);
    chk("done_seen", W'(done), W'(1));
  endtask

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] cas, input logic [2:0] exp_res);
    int cyc;
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b; cas_in = cas;
    @(negedge clk);
    // Accepted at the previous edge; scramble inputs to prove they were latched.
    start = 1'b0; op_a = ~a; op_b = a; cas_in = ~cas;
    chk({name, "_busy"}, W'(busy), W'(1));
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_done"}, W'(done), W'(1));
    chk({name, "_latency"}, W'(cyc), W'(N + 1));
    chk({name, "_result"}, W'(result), W'(exp_res));
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) c++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] xa [3];
    logic [W-1:0] xb [3];
    logic [2:0]   xr [3];
    int           c;
    int           last_done;

    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; cas_in = 3'b000;
    repeat (3) @(negedge clk);
    chk("rst_busy",    W'(busy),    W'(0));
    chk("rst_done",    W'(done),    W'(0));
    chk("rst_result",  W'(result),  W'(0));
    chk("rst_cmp_a",   W'(cmp_a),   W'(0));
    chk("rst_cmp_b",   W'(cmp_b),   W'(0));
    chk("rst_cmp_cas", W'(cmp_cas), W'(0));
    rst_n = 1'b1;

    // Equal operands, equal cascade; MSB dominance; cascade propagation.
    do_op("t1_eq",     16'h1234, 16'h1234, 3'b010, 3'b010);
    do_op("t2_gt",     16'h1235, 16'h1234, 3'b010, 3'b100);
    do_op("t2_lt_msb", 16'h0FFF, 16'h1000, 3'b010, 3'b001);
    do_op("t2_gt_msb", 16'h1000, 16'h0FFF, 3'b010, 3'b100);
    do_op("t3_cas_gt", 16'hBEEF, 16'hBEEF, 3'b100, 3'b100);
    do_op("t3_cas_lt", 16'hBEEF, 16'hBEEF, 3'b001, 3'b001);
    do_op("t3_eq_pri", 16'h00A0, 16'h00A0, 3'b111, 3'b010);

    // Start while busy is ignored.
    @(negedge clk);
    start = 1'b1; op_a = 16'h1235; op_b = 16'h1234; cas_in = 3'b010;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op_a = 16'h0000; op_b = 16'hFFFF; cas_in = 3'b001;
    @(negedge clk);
    start = 1'b0;
    wait_done(c);
    chk("t4_result", W'(result), W'(3'b100));
    count_done(10, c);
    chk("t4_single_done", W'(c), W'(0));

    // Start held high: back-to-back, operands taken in each DONE cycle.
    xa[0] = 16'h0001; xb[0] = 16'h0002; xr[0] = 3'b001;
    xa[1] = 16'hFFFF; xb[1] = 16'h0000; xr[1] = 3'b100;
    xa[2] = 16'hA5A5; xb[2] = 16'hA5A5; xr[2] = 3'b010;
    @(negedge clk);
    start = 1'b1; op_a = xa[0]; op_b = xb[0]; cas_in = 3'b010;
    last_done = 0;
    for (int i = 0; i < 3; i++) begin
      wait_done(c);
      chk($sformatf("t5_result%0d", i), W'(result), W'(xr[i]));
      if (i > 0) chk($sformatf("t5_gap%0d", i), W'(cyc_cnt - last_done), W'(N + 1));
      last_done = cyc_cnt;
      if (i < 2) begin
        op_a = xa[i+1]; op_b = xb[i+1];
      end else begin
        start = 1'b0;
      end
    end

    // Reset mid-RUN aborts the operation.
    @(negedge clk);
    start = 1'b1; op_a = 16'h1111; op_b = 16'h2222; cas_in = 3'b010;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_busy",    W'(busy),    W'(0));
    chk("t6_done",    W'(done),    W'(0));
    chk("t6_result",  W'(result),  W'(0));
    chk("t6_cmp_a",   W'(cmp_a),   W'(0));
    chk("t6_cmp_cas", W'(cmp_cas), W'(0));
    rst_n = 1'b1;
    count_done(8, c);
    chk("t6_no_done", W'(c), W'(0));
    do_op("t6_fresh", 16'h2222, 16'h1111, 3'b010, 3'b100);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
